// File: rtl/conv_last_to_first_with_ready_if.sv
// Handshake bundle for the last-to-first converter: upstream beats tagged with 'last',
// downstream beats tagged with 'first' plus their position within the packet.
interface conv_last_to_first_with_ready_if #(
    parameter int width       = 8,
    parameter int index_width = 8
);
    logic                   up_valid;
    logic                   up_ready;
    logic                   up_last;
    logic [width-1:0]       up_data;
    logic                   down_valid;
    logic                   down_ready;
    logic                   down_first;
    logic [width-1:0]       down_data;
    logic [index_width-1:0] down_index;

    // Drives the converter: produces upstream beats, consumes downstream beats.
    modport master (
        output up_valid, up_last, up_data, down_ready,
        input  up_ready, down_valid, down_first, down_data, down_index
    );

    // The converter itself.
    modport slave (
        input  up_valid, up_last, up_data, down_ready,
        output up_ready, down_valid, down_first, down_data, down_index
    );
endinterface

// File: rtl/conv_last_to_first_with_ready.sv
// Retags a last-framed stream as first-framed with a saturating beat index; 1-cycle latency.
// Two-entry output buffer: up_ready depends on occupancy only, so full rate holds under stalls.
module conv_last_to_first_with_ready #(
    parameter int width       = 8,
    parameter int index_width = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    conv_last_to_first_with_ready_if.slave  bus
);
    typedef struct packed {
        logic [width-1:0]       data;
        logic                   first;
        logic [index_width-1:0] index;
    } entry_t;

    localparam logic [index_width-1:0] one_idx = index_width'(1);

    entry_t                 slot [2];
    entry_t                 incoming;
    entry_t                 head;
    logic [1:0]             occ;
    logic                   sop;
    logic [index_width-1:0] cnt;
    logic                   push;
    logic                   pop;

    assign bus.up_ready   = ~reset & (occ != 2'd2);
    assign bus.down_valid = ~reset & (occ != 2'd0);

    assign push = bus.up_valid & bus.up_ready;
    assign pop  = bus.down_valid & bus.down_ready;

    // The beat is tagged with the framing state as it stood before this push.
    assign incoming = {bus.up_data, sop, cnt};

    assign head           = bus.down_valid ? slot[0] : '0;
    assign bus.down_data  = head.data;
    assign bus.down_first = head.first;
    assign bus.down_index = head.index;

    always_ff @(posedge clock) begin
        if (reset) begin
            occ     <= 2'd0;
            sop     <= 1'b1;
            cnt     <= '0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            if (push) begin
                sop <= bus.up_last;
                if (bus.up_last)
                    cnt <= '0;
                else if (!(&cnt))
                    cnt <= cnt + one_idx;
            end

            // slot[0] is always the head; a pop shifts slot[1] forward.
            case ({push, pop})
                2'b10: begin
                    slot[occ[0]] <= incoming;
                    occ          <= occ + 2'd1;
                end
                2'b01: begin
                    slot[0] <= slot[1];
                    slot[1] <= '0;
                    occ     <= occ - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held: the new beat becomes the head.
                    slot[0] <= incoming;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_last_to_first_with_ready.sv
// Scoreboard bench for conv_last_to_first_with_ready: directed beats queue their expected
// tags, a negedge monitor pops and compares each downstream handshake.
module tb_conv_last_to_first_with_ready;
    typedef struct {
        logic [7:0] d;
        logic       f;
        logic [7:0] i;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    conv_last_to_first_with_ready_if #(.width(8), .index_width(8)) b1 ();
    conv_last_to_first_with_ready_if #(.width(8), .index_width(2)) b2 ();

    conv_last_to_first_with_ready #(.width(8), .index_width(8)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    conv_last_to_first_with_ready #(.width(8), .index_width(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    beat_t q1[$];
    beat_t q2[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    bit    streaming = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int which, input logic v, input logic r,
                       input logic [7:0] d, input logic f, input logic [7:0] i);
        beat_t e;
        int    sz;
        sz = (which == 0) ? q1.size() : q2.size();
        if (v) begin
            if (sz == 0) begin
                if (r) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat dut%0d: got data %0h, expected none", which + 1, d);
                end
            end else begin
                e = (which == 0) ? q1[0] : q2[0];
                check(r ? "pop_data" : "hold_data", 32'(d), 32'(e.d));
                check(r ? "pop_first" : "hold_first", 32'(f), 32'(e.f));
                check(r ? "pop_index" : "hold_index", 32'(i), 32'(e.i));
                if (r) begin
                    if (which == 0) void'(q1.pop_front());
                    else            void'(q2.pop_front());
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(0, b1.down_valid, b1.down_ready, b1.down_data, b1.down_first, b1.down_index);
            mon(1, b2.down_valid, b2.down_ready, b2.down_data, b2.down_first, {6'b0, b2.down_index});
            if (streaming) check("stream_up_ready", 32'(b1.up_ready), 32'd1);
        end
    end

    // Offer one beat until accepted; the expected tags are queued when the beat is issued.
    task automatic send(input int which, input logic [7:0] d, input logic last,
                        input logic f, input logic [7:0] idx, input bit expect_it);
        beat_t e;
        logic  rdy;
        int    waits = 0;
        if (expect_it) begin
            e.d = d; e.f = f; e.i = idx;
            if (which == 0) q1.push_back(e);
            else            q2.push_back(e);
        end
        if (which == 0) begin
            b1.up_valid = 1'b1; b1.up_data = d; b1.up_last = last;
        end else begin
            b2.up_valid = 1'b1; b2.up_data = d; b2.up_last = last;
        end
        forever begin
            @(negedge clock);
            rdy = (which == 0) ? b1.up_ready : b2.up_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout dut%0d: beat %0h not accepted, expected acceptance", which + 1, d);
                break;
            end
        end
        if (which == 0) b1.up_valid = 1'b0;
        else            b2.up_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_q1_left", 32'(q1.size()), 32'd0);
        check("drain_q2_left", 32'(q2.size()), 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int start;
        logic [7:0] tv1 [3];
        logic [7:0] a;
        tv1[0] = 8'h11; tv1[1] = 8'h22; tv1[2] = 8'h33;

        b1.up_valid = 0; b1.up_last = 0; b1.up_data = 0; b1.down_ready = 1;
        b2.up_valid = 0; b2.up_last = 0; b2.up_data = 0; b2.down_ready = 1;

        // Reset state
        repeat (2) begin
            @(negedge clock);
            check("rst_up_ready", 32'(b1.up_ready), 32'd0);
            check("rst_down_valid", 32'(b1.down_valid), 32'd0);
            check("rst_down_data", 32'(b1.down_data), 32'd0);
            check("rst2_up_ready", 32'(b2.up_ready), 32'd0);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("idle_up_ready", 32'(b1.up_ready), 32'd1);
        check("idle_down_valid", 32'(b1.down_valid), 32'd0);
        tick();

        // Single-beat packets, each visible one cycle after its push
        for (int k = 0; k < 3; k++) begin
            send(0, tv1[k], 1'b1, 1'b1, 8'd0, 1);
            @(negedge clock);
            check("lat1_down_valid", 32'(b1.down_valid), 32'd1);
            check("lat1_down_data", 32'(b1.down_data), 32'(tv1[k]));
            tick();
        end
        wait_drain();
        @(negedge clock);
        check("empty_data_zero", 32'(b1.down_data), 32'd0);
        check("empty_first_zero", 32'(b1.down_first), 32'd0);
        check("empty_index_zero", 32'(b1.down_index), 32'd0);
        tick();

        // 4-beat then 2-beat packet
        send(0, 8'hA0, 0, 1, 8'd0, 1);
        send(0, 8'hA1, 0, 0, 8'd1, 1);
        send(0, 8'hA2, 0, 0, 8'd2, 1);
        send(0, 8'hA3, 1, 0, 8'd3, 1);
        send(0, 8'hB0, 0, 1, 8'd0, 1);
        send(0, 8'hB1, 1, 0, 8'd1, 1);
        wait_drain();

        // Back-pressure: two beats fill the buffer, the third waits
        b1.down_ready = 1'b0;
        send(0, 8'hD0, 0, 1, 8'd0, 1);
        send(0, 8'hD1, 0, 0, 8'd1, 1);
        @(negedge clock);
        check("bp_up_ready_low", 32'(b1.up_ready), 32'd0);
        check("bp_head_data", 32'(b1.down_data), 32'h0D0);
        tick();
        fork
            send(0, 8'hD2, 1, 0, 8'd2, 1);
            begin
                repeat (3) tick();
                b1.down_ready = 1'b1;
            end
        join
        wait_drain();

        // Continuous streaming, packets of 5
        streaming = 1;
        start = cyc;
        for (int k = 0; k < 20; k++) begin
            a = 8'hC0 + 8'(k);
            send(0, a, (k % 5) == 4, (k % 5) == 0, 8'(k % 5), 1);
        end
        check("stream_cycles", 32'(cyc - start), 32'd20);
        streaming = 0;
        wait_drain();

        // Reset in the middle of a buffered packet discards it
        b1.down_ready = 1'b0;
        send(0, 8'h01, 0, 0, 8'd0, 0);
        send(0, 8'h02, 0, 0, 8'd0, 0);
        @(negedge clock);
        check("pre_rst_buffered", 32'(b1.down_valid), 32'd1);
        tick();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("midrst_up_ready", 32'(b1.up_ready), 32'd0);
            check("midrst_down_valid", 32'(b1.down_valid), 32'd0);
            tick();
        end
        reset = 1'b0;
        b1.down_ready = 1'b1;
        @(negedge clock);
        check("post_rst_empty", 32'(b1.down_valid), 32'd0);
        tick();
        send(0, 8'h5A, 1, 1, 8'd0, 1);
        wait_drain();

        // Two-bit index saturation
        send(1, 8'hE0, 0, 1, 8'd0, 1);
        send(1, 8'hE1, 0, 0, 8'd1, 1);
        send(1, 8'hE2, 0, 0, 8'd2, 1);
        send(1, 8'hE3, 0, 0, 8'd3, 1);
        send(1, 8'hE4, 0, 0, 8'd3, 1);
        send(1, 8'hE5, 1, 0, 8'd3, 1);
        send(1, 8'hF0, 1, 1, 8'd0, 1);
        wait_drain();

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
